// File: rtl/change_dispenser.sv
// change_dispenser: drains the change owed after a sale, largest coin first,
// over a valid/ready handshake to the coin mechanism.
//
// Ports:
//   clk, reset        - rising-edge clock, synchronous active-high reset
//   start             - request a transaction (sampled only in IDLE)
//   total, price      - accumulated credit and item price, latched on start
//   busy              - high while checking credit or dispensing
//   done              - one-cycle completion pulse
//   err               - insufficient credit; held until the next accepted start
//   coin_valid        - a coin is offered to the mechanism
//   coin_value        - denomination of the offered coin
//   coin_ready        - mechanism accepts the offered coin
//   remaining         - change still to be dispensed
//   coin_count        - coins dispensed in the current transaction
module change_dispenser #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DEN_HI = 5,
  parameter int unsigned DEN_LO = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] total,
  input  logic [WIDTH-1:0] price,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             coin_valid,
  output logic [3:0]       coin_value,
  input  logic             coin_ready,
  output logic [WIDTH-1:0] remaining,
  output logic [WIDTH-1:0] coin_count
);

  localparam int unsigned COIN_W = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CHECK,
    S_DISPENSE,
    S_DONE
  } state_t;

  state_t              r_state;
  logic [WIDTH-1:0]    r_total;
  logic [WIDTH-1:0]    r_price;
  logic [WIDTH-1:0]    r_remaining;
  logic [WIDTH-1:0]    r_coin_count;
  logic                r_err;
  logic                r_busy;
  logic                r_done;
  logic                r_coin_valid;

  state_t              w_state;
  logic [WIDTH-1:0]    w_total;
  logic [WIDTH-1:0]    w_price;
  logic [WIDTH-1:0]    w_remaining;
  logic [WIDTH-1:0]    w_coin_count;
  logic                w_err;
  logic                w_busy;
  logic                w_done;
  logic                w_coin_valid;

  logic [COIN_W-1:0]   w_coin_value;
  logic [WIDTH-1:0]    w_diff;
  logic [WIDTH-1:0]    w_rem_after;

  // Greedy denomination, decoded from the registered balance so it stays
  // stable for as long as the offer is stalled.
  assign w_coin_value = (r_remaining >= WIDTH'(DEN_HI)) ? COIN_W'(DEN_HI)
                                                        : COIN_W'(DEN_LO);
  assign w_diff       = r_total - r_price;
  assign w_rem_after  = r_remaining - WIDTH'(w_coin_value);

  // Next-state and next-output logic; registered outputs are computed from
  // the state being entered.
  always_comb begin
    w_state      = r_state;
    w_total      = r_total;
    w_price      = r_price;
    w_remaining  = r_remaining;
    w_coin_count = r_coin_count;
    w_err        = r_err;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    w_coin_valid = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_total      = total;
          w_price      = price;
          w_coin_count = '0;
          w_err        = 1'b0;
          w_state      = S_CHECK;
          w_busy       = 1'b1;
        end
      end
      S_CHECK: begin
        if (r_total < r_price) begin
          w_err       = 1'b1;
          w_remaining = '0;
          w_state     = S_DONE;
          w_done      = 1'b1;
        end else begin
          w_remaining = w_diff;
          if (w_diff != '0) begin
            w_state      = S_DISPENSE;
            w_busy       = 1'b1;
            w_coin_valid = 1'b1;
          end else begin
            w_state = S_DONE;
            w_done  = 1'b1;
          end
        end
      end
      S_DISPENSE: begin
        w_busy       = 1'b1;
        w_coin_valid = 1'b1;
        if (r_coin_valid && coin_ready) begin
          w_remaining  = w_rem_after;
          w_coin_count = r_coin_count + WIDTH'(1);
          if (w_rem_after == '0) begin
            w_state      = S_DONE;
            w_busy       = 1'b0;
            w_coin_valid = 1'b0;
            w_done       = 1'b1;
          end
        end
      end
      S_DONE: begin
        w_state = S_IDLE;
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_total      <= '0;
      r_price      <= '0;
      r_remaining  <= '0;
      r_coin_count <= '0;
      r_err        <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_coin_valid <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_total      <= w_total;
      r_price      <= w_price;
      r_remaining  <= w_remaining;
      r_coin_count <= w_coin_count;
      r_err        <= w_err;
      r_busy       <= w_busy;
      r_done       <= w_done;
      r_coin_valid <= w_coin_valid;
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign err        = r_err;
  assign coin_valid = r_coin_valid;
  assign coin_value = w_coin_value;
  assign remaining  = r_remaining;
  assign coin_count = r_coin_count;

endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: scenario tasks drive change_dispenser; expected coins
// are queued when a transaction starts and compared against coins observed on
// the handshake.
module tb_change_dispenser;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] total;
  logic [15:0] price;
  logic        busy;
  logic        done;
  logic        err;
  logic        coin_valid;
  logic [3:0]  coin_value;
  logic        coin_ready;
  logic [15:0] remaining;
  logic [15:0] coin_count;

  typedef struct packed {
    logic [3:0]  val;
    logic [15:0] rem;
  } coin_t;

  coin_t exp_q[$];
  coin_t obs_q[$];

  int total_cnt = 0;
  int bad_cnt   = 0;

  change_dispenser #(.WIDTH(16), .DEN_HI(5), .DEN_LO(1)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .total      (total),
    .price      (price),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .coin_valid (coin_valid),
    .coin_value (coin_value),
    .coin_ready (coin_ready),
    .remaining  (remaining),
    .coin_count (coin_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every coin that will transfer on the coming rising edge.
  always @(negedge clk) begin
    if (!reset && coin_valid && coin_ready)
      obs_q.push_back('{val: coin_value, rem: remaining});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_coin(input int v, input int r);
    exp_q.push_back('{val: 4'(v), rem: 16'(r)});
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; coin_ready = 1'b0; total = '0; price = '0;
    tick(); tick();
    total_cnt++;
    if ({busy, done, err, coin_valid} !== 4'b0000) begin
      bad_cnt++; $display("FAIL reset_flags got=%b want=0000", {busy, done, err, coin_valid});
    end
    total_cnt++;
    if (remaining !== 16'd0 || coin_count !== 16'd0) begin
      bad_cnt++; $display("FAIL reset_counts rem=%0d cnt=%0d want 0/0", remaining, coin_count);
    end
    total_cnt++;
    if (coin_value !== 4'd1) begin
      bad_cnt++; $display("FAIL reset_coin_value got=%0d want=1", coin_value);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int n;
    coin_t e, o;
    obs_q.delete();
    push_coin(5, 12); push_coin(5, 7); push_coin(1, 2); push_coin(1, 1);
    total = 16'd17; price = 16'd5; coin_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    total_cnt++;
    if (busy !== 1'b1 || coin_valid !== 1'b0) begin
      bad_cnt++; $display("FAIL basic_check busy=%b valid=%b want 1/0", busy, coin_valid);
    end
    tick();
    total_cnt++;
    if (coin_valid !== 1'b1 || remaining !== 16'd12 || coin_value !== 4'd5) begin
      bad_cnt++; $display("FAIL basic_first valid=%b rem=%0d val=%0d want 1/12/5", coin_valid, remaining, coin_value);
    end
    n = 0;
    while (!done && n < 50) begin tick(); n++; end
    total_cnt++;
    if (n !== 4) begin
      bad_cnt++; $display("FAIL basic_latency got=%0d want=4", n);
    end
    total_cnt++;
    if (err !== 1'b0 || remaining !== 16'd0 || coin_count !== 16'd4 || busy !== 1'b0) begin
      bad_cnt++; $display("FAIL basic_done err=%b rem=%0d cnt=%0d busy=%b want 0/0/4/0", err, remaining, coin_count, busy);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total_cnt++;
      if (obs_q.size() == 0) begin
        bad_cnt++; $display("FAIL basic_coin missing want val=%0d rem=%0d", e.val, e.rem);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          bad_cnt++; $display("FAIL basic_coin got val=%0d rem=%0d want val=%0d rem=%0d", o.val, o.rem, e.val, e.rem);
        end
      end
    end
    total_cnt++;
    if (obs_q.size() != 0) begin
      bad_cnt++; $display("FAIL basic_extra got=%0d extra coins want=0", obs_q.size());
    end
    tick();
    total_cnt++;
    if (done !== 1'b0 || coin_count !== 16'd4) begin
      bad_cnt++; $display("FAIL basic_idle done=%b cnt=%0d want 0/4", done, coin_count);
    end
  endtask

  task automatic test_zero_change();
    obs_q.delete();
    total = 16'd8; price = 16'd8; coin_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    total_cnt++;
    if (done !== 1'b1 || err !== 1'b0 || remaining !== 16'd0 || coin_count !== 16'd0) begin
      bad_cnt++; $display("FAIL zero_done done=%b err=%b rem=%0d cnt=%0d want 1/0/0/0", done, err, remaining, coin_count);
    end
    tick();
    total_cnt++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad_cnt++; $display("FAIL zero_idle done=%b busy=%b want 0/0", done, busy);
    end
    total_cnt++;
    if (obs_q.size() != 0) begin
      bad_cnt++; $display("FAIL zero_no_coins got=%0d want=0", obs_q.size());
    end
    // Back-to-back: start presented right away in IDLE must be accepted.
    total = 16'd8; price = 16'd8; start = 1'b1;
    tick();
    start = 1'b0;
    total_cnt++;
    if (busy !== 1'b1) begin
      bad_cnt++; $display("FAIL zero_back_to_back busy=%b want 1", busy);
    end
    tick(); tick();
  endtask

  task automatic test_err();
    obs_q.delete();
    total = 16'd3; price = 16'd7; coin_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    total_cnt++;
    if (done !== 1'b1 || err !== 1'b1 || coin_valid !== 1'b0 || remaining !== 16'd0) begin
      bad_cnt++; $display("FAIL err_done done=%b err=%b valid=%b rem=%0d want 1/1/0/0", done, err, coin_valid, remaining);
    end
    tick(); tick();
    total_cnt++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      bad_cnt++; $display("FAIL err_hold err=%b busy=%b want 1/0", err, busy);
    end
    total = 16'd8; price = 16'd8; start = 1'b1;
    tick();
    start = 1'b0;
    total_cnt++;
    if (err !== 1'b0) begin
      bad_cnt++; $display("FAIL err_clear err=%b want 0", err);
    end
    total_cnt++;
    if (obs_q.size() != 0) begin
      bad_cnt++; $display("FAIL err_no_coins got=%0d want=0", obs_q.size());
    end
    tick(); tick();
  endtask

  task automatic test_stall();
    int n;
    coin_t e, o;
    obs_q.delete();
    push_coin(5, 6); push_coin(1, 1);
    total = 16'd6; price = 16'd0; coin_ready = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      total_cnt++;
      if (coin_valid !== 1'b1 || coin_value !== 4'd5 || remaining !== 16'd6) begin
        bad_cnt++; $display("FAIL stall_hold cyc=%0d valid=%b val=%0d rem=%0d want 1/5/6", i, coin_valid, coin_value, remaining);
      end
      tick();
    end
    coin_ready = 1'b1;
    n = 0;
    while (!done && n < 50) begin tick(); n++; end
    total_cnt++;
    if (done !== 1'b1 || coin_count !== 16'd2) begin
      bad_cnt++; $display("FAIL stall_done done=%b cnt=%0d want 1/2", done, coin_count);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total_cnt++;
      if (obs_q.size() == 0) begin
        bad_cnt++; $display("FAIL stall_coin missing want val=%0d rem=%0d", e.val, e.rem);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          bad_cnt++; $display("FAIL stall_coin got val=%0d rem=%0d want val=%0d rem=%0d", o.val, o.rem, e.val, e.rem);
        end
      end
    end
    total_cnt++;
    if (obs_q.size() != 0) begin
      bad_cnt++; $display("FAIL stall_extra got=%0d extra coins want=0", obs_q.size());
    end
    tick();
  endtask

  task automatic test_start_ignored();
    int n;
    coin_t e, o;
    obs_q.delete();
    push_coin(5, 12); push_coin(5, 7); push_coin(1, 2); push_coin(1, 1);
    total = 16'd17; price = 16'd5; coin_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    total = 16'd99; price = 16'd0; start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!done && n < 50) begin tick(); n++; end
    total_cnt++;
    if (done !== 1'b1 || coin_count !== 16'd4 || remaining !== 16'd0) begin
      bad_cnt++; $display("FAIL ignore_done done=%b cnt=%0d rem=%0d want 1/4/0", done, coin_count, remaining);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total_cnt++;
      if (obs_q.size() == 0) begin
        bad_cnt++; $display("FAIL ignore_coin missing want val=%0d rem=%0d", e.val, e.rem);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          bad_cnt++; $display("FAIL ignore_coin got val=%0d rem=%0d want val=%0d rem=%0d", o.val, o.rem, e.val, e.rem);
        end
      end
    end
    total_cnt++;
    if (obs_q.size() != 0) begin
      bad_cnt++; $display("FAIL ignore_extra got=%0d extra coins want=0", obs_q.size());
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int n;
    coin_t e, o;
    obs_q.delete();
    push_coin(5, 12);
    total = 16'd12; price = 16'd0; coin_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    // Reset wins over a simultaneous start and coin_ready.
    reset = 1'b1; start = 1'b1; total = 16'd50;
    tick();
    total_cnt++;
    if ({busy, done, err, coin_valid} !== 4'b0000 || remaining !== 16'd0 || coin_count !== 16'd0 || coin_value !== 4'd1) begin
      bad_cnt++; $display("FAIL midreset_outputs flags=%b rem=%0d cnt=%0d val=%0d want 0000/0/0/1", {busy, done, err, coin_valid}, remaining, coin_count, coin_value);
    end
    reset = 1'b0; start = 1'b0;
    tick();
    total_cnt++;
    if (busy !== 1'b0 || coin_valid !== 1'b0) begin
      bad_cnt++; $display("FAIL midreset_idle busy=%b valid=%b want 0/0", busy, coin_valid);
    end
    push_coin(1, 2); push_coin(1, 1);
    total = 16'd2; price = 16'd0; start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!done && n < 50) begin tick(); n++; end
    total_cnt++;
    if (done !== 1'b1 || coin_count !== 16'd2 || err !== 1'b0) begin
      bad_cnt++; $display("FAIL midreset_fresh done=%b cnt=%0d err=%b want 1/2/0", done, coin_count, err);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total_cnt++;
      if (obs_q.size() == 0) begin
        bad_cnt++; $display("FAIL midreset_coin missing want val=%0d rem=%0d", e.val, e.rem);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          bad_cnt++; $display("FAIL midreset_coin got val=%0d rem=%0d want val=%0d rem=%0d", o.val, o.rem, e.val, e.rem);
        end
      end
    end
    total_cnt++;
    if (obs_q.size() != 0) begin
      bad_cnt++; $display("FAIL midreset_extra got=%0d extra coins want=0", obs_q.size());
    end
    tick();
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; coin_ready = 1'b0; total = '0; price = '0;
    test_reset();
    test_basic();
    test_zero_change();
    test_err();
    test_stall();
    test_start_ignored();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule

// File: doc/change_dispenser.md
# change_dispenser

Dispenses the change owed after a sale, coin by coin, over a valid/ready handshake to the coin mechanism. It sits downstream of the 16-bit credit accumulator. On `start` it latches the accumulated credit and the item price, checks that the credit is sufficient, and computes the change. It then drains the change in high-denomination coins first, and finishes with a one-cycle `done` pulse.

## Interface
Parameters:
- `WIDTH`, 16: width of credit, price, remaining and coin-count datapaths.
- `DEN_HI`, 5: large coin value; must satisfy 1 < `DEN_HI` < 16.
- `DEN_LO`, 1: small coin value; fixed at 1 so every balance terminates.

Ports:
- `clk`, input, 1: clock, rising-edge.
- `reset`, input, 1: reset, synchronous, active-high.
- `start`, input, 1: request a transaction; sampled only in IDLE.
- `total`, input, `WIDTH`: accumulated credit; latched on accepted `start`.
- `price`, input, `WIDTH`: item price; latched on accepted `start`.
- `busy`, output, 1: high in CHECK and DISPENSE.
- `done`, output, 1: one-cycle pulse in DONE.
- `err`, output, 1: insufficient credit; valid while `done`=1, held until next accepted `start`.
- `coin_valid`, output, 1: a coin is offered to the mechanism.
- `coin_value`, output, 4: denomination of the offered coin (`DEN_HI` or `DEN_LO`).
- `coin_ready`, input, 1: mechanism accepts the offered coin.
- `remaining`, output, `WIDTH`: change still to be dispensed.
- `coin_count`, output, `WIDTH`: coins dispensed in the current transaction.

## Operation
- States: IDLE, CHECK, DISPENSE, DONE. State and all outputs are registered; `coin_value` is decoded from the registered `remaining`.
- IDLE:
  - On `start`=1: latch `total`/`price` into internal registers, clear `coin_count`, clear `err`, go to CHECK.
  - `start` is ignored in every other state.
- CHECK (exactly 1 cycle):
  - If latched total < latched price: set `err`=1, `remaining`=0, go to DONE.
  - Else: `remaining` = total − price (`WIDTH`-bit, cannot underflow after the check).
  - Go to DISPENSE if `remaining` != 0, else go to DONE.
- DISPENSE:
  - `coin_valid`=1.
  - `coin_value` = `DEN_HI` if `remaining` >= `DEN_HI`, else `DEN_LO`.
  - Transfer occurs on a cycle where `coin_valid`=1 and `coin_ready`=1. On transfer: `remaining` −= `coin_value`, `coin_count` += 1.
  - If the post-transfer `remaining` is 0, go to DONE; otherwise stay and offer the next coin on the following cycle (back-to-back transfers allowed).
- DONE: `done`=1 for exactly one cycle, then IDLE.
- `remaining` and `coin_count` hold their final values in IDLE until the next accepted `start`.
- Coin sequence is greedy: floor(change/`DEN_HI`) large coins, then (change mod `DEN_HI`) small coins.
- `coin_count` cannot overflow for `WIDTH`=16 with `DEN_HI`=5: maximum count is 13110.
- `coin_ready` is don't-care outside DISPENSE.

## Timing
- `start` sampled at edge k:
  - `busy`=1 after k.
  - CHECK resolves at k+1.
  - First `coin_valid` after k+1.
- Zero change or `err`: `done` high in the cycle after k+1; IDLE after k+2; new `start` accepted at edge k+3.
- Handshake:
  - Once `coin_valid` rises, `coin_valid` and `coin_value` stay stable until the transfer.
  - With `coin_ready` held high, one coin transfers per cycle.
  - The last transfer at edge m gives `done` after m and IDLE after m+1.
- Reset:
  - State returns to IDLE.
  - `busy`, `done`, `err`, `coin_valid`, `remaining`, `coin_count` all go to 0; `coin_value` reads `DEN_LO`.
  - An offered coin is withdrawn with no transfer.
  - `reset` overrides a simultaneous `start` or `coin_ready`.
- `start` held high across DONE is not accepted until IDLE.

## Test plan
- total=17, price=5, `coin_ready`=1: coins 5,5,1,1 on consecutive cycles; `remaining` 12→7→2→1→0; `coin_count`=4; `done` pulse with `err`=0.
- total=8, price=8: no `coin_valid`; `done` two cycles after the `start` edge; `remaining`=0, `coin_count`=0, `err`=0.
- total=3, price=7: no coins; `done` with `err`=1; `err` stays 1 in IDLE and clears on the next accepted `start`.
- total=6, price=0, `coin_ready` low for 3 cycles then high: `coin_value`=5 held stable while stalled; then coin 1; `coin_count`=2.
- `start` pulsed during DISPENSE with new total=99: ignored; the original sequence completes unchanged.
- `reset` asserted mid-dispense of 12 (after one coin): next cycle all outputs are 0 and state is IDLE; a fresh `start` with total=2, price=0 yields coins 1,1.
